// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I/RV64I decode stage: base opcodes, the
// instruction-format encoding and the decoded-instruction record.
package decode_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       illegal;
  } dec_t;

  // Every base opcode ends in 2'b11, so a compressed-space word (inst[1:0] != 11)
  // never matches and falls through to FMT_NONE.
  function automatic fmt_e classify(input logic [6:0] op);
    case (op)
      OP:                                    return FMT_R;
      OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM:  return FMT_I;
      STORE:                                 return FMT_S;
      BRANCH:                                return FMT_B;
      LUI, AUIPC:                            return FMT_U;
      JAL:                                   return FMT_J;
      default:                               return FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects and sign-extends the immediate of each base
// instruction format to XLEN bits. Purely combinational.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;

  // NOTE: raw gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    raw = '0;
    case (fmt)
      FMT_I:   raw = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   raw = {inst[31:12], 12'b0};
      FMT_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  // Widening a signed value replicates bit 31 up to XLEN (RV64 upper half).
  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/decode_stage.sv
// RV32I/RV64I decode pipeline stage: valid/ready handshaked, registered outputs,
// optional skid register giving full throughput behind a registered in_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  dec_t            dec_d;
  dec_t            out_dec;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] out_imm;
  logic [PC_W-1:0] out_pc_q;
  logic            in_fire;
  logic            load_out;

  assign dec_d = '{
    opcode:  in_inst[6:0],
    rd:      in_inst[11:7],
    funct3:  in_inst[14:12],
    rs1:     in_inst[19:15],
    rs2:     in_inst[24:20],
    funct7:  in_inst[31:25],
    fmt:     classify(in_inst[6:0]),
    illegal: (classify(in_inst[6:0]) == FMT_NONE)
  };

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (in_inst[31:7]),
    .fmt  (dec_d.fmt),
    .imm  (imm_d)
  );

  assign in_fire  = in_valid && in_ready;
  assign load_out = !out_valid || out_ready;

  if (SKID != 0) begin : g_skid
    dec_t            skid_dec;
    logic [XLEN-1:0] skid_imm;
    logic [PC_W-1:0] skid_pc;
    logic            skid_valid;
    logic            in_ready_q;

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge values; data registers are reset too because the outputs must
    // read zero out of reset.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        out_valid  <= 1'b0;
        out_dec    <= '0;
        out_imm    <= '0;
        out_pc_q   <= '0;
        skid_valid <= 1'b0;
        skid_dec   <= '0;
        skid_imm   <= '0;
        skid_pc    <= '0;
        in_ready_q <= 1'b1;
      end else if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (load_out) begin
        if (skid_valid) begin
          // in_ready was low, so nothing new can arrive while the skid drains.
          out_valid  <= 1'b1;
          out_dec    <= skid_dec;
          out_imm    <= skid_imm;
          out_pc_q   <= skid_pc;
          skid_valid <= 1'b0;
          in_ready_q <= 1'b1;
        end else begin
          out_valid <= in_fire;
          if (in_fire) begin
            out_dec  <= dec_d;
            out_imm  <= imm_d;
            out_pc_q <= in_pc;
          end
        end
      end else if (in_fire) begin
        skid_valid <= 1'b1;
        skid_dec   <= dec_d;
        skid_imm   <= imm_d;
        skid_pc    <= in_pc;
        in_ready_q <= 1'b0;
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        out_valid <= 1'b0;
        out_dec   <= '0;
        out_imm   <= '0;
        out_pc_q  <= '0;
      end else if (flush) begin
        out_valid <= 1'b0;
      end else if (load_out) begin
        out_valid <= in_fire;
        if (in_fire) begin
          out_dec  <= dec_d;
          out_imm  <= imm_d;
          out_pc_q <= in_pc;
        end
      end
    end

    assign in_ready = load_out;
  end

  assign out_pc  = out_pc_q;
  assign opcode  = out_dec.opcode;
  assign rd      = out_dec.rd;
  assign funct3  = out_dec.funct3;
  assign rs1     = out_dec.rs1;
  assign rs2     = out_dec.rs2;
  assign funct7  = out_dec.funct7;
  assign imm     = out_imm;
  assign fmt     = out_dec.fmt;
  assign illegal = out_dec.illegal;

endmodule
